seg_charge_bar_display: RTL and testbench

//  Consumes the character's jump-charge counter and drives the 8-digit 7-segment

---
 rtl/seg_pkg.sv | 20 ++
 rtl/seg_bar_decode.sv | 27 ++
 rtl/seg_charge_bar_display.sv | 134 +++++++++++++
 tb/tb_seg_charge_bar_display.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants and types for the 7-segment charge bar display.
package seg_pkg;

  localparam int DIGITS    = 8;
  localparam int BAR_STEPS = 16;

  // Segment patterns ordered {g,f,e,d,c,b,a}, active low.
  localparam logic [6:0] SEG_OFF    = 7'h7F;
  localparam logic [6:0] SEG_BAR_L  = 7'b1001111;
  localparam logic [6:0] SEG_BAR_LR = 7'b1001001;

  typedef logic [4:0] level_t;
  typedef logic [2:0] digit_t;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_t;

endpackage

// File: rtl/seg_bar_decode.sv
// Maps the latched bar level and the scanned digit to a segment pattern.
module seg_bar_decode
  import seg_pkg::*;
(
  input  level_t     level,
  input  digit_t     k,
  input  logic       blink_off,
  output logic [6:0] segs
);

  digit_t bar_idx;
  level_t left_thr;
  level_t right_thr;

  // Digit k = 7 is the leftmost digit, i.e. bar index 0.
  always_comb begin
    bar_idx   = digit_t'(DIGITS - 1) - k;
    left_thr  = {1'b0, bar_idx, 1'b0} + 5'd1;
    right_thr = {1'b0, bar_idx, 1'b0} + 5'd2;
    segs      = SEG_OFF;
    if (!blink_off) begin
      if (level >= right_thr)     segs = SEG_BAR_LR;
      else if (level >= left_thr) segs = SEG_BAR_L;
    end
  end

endmodule

// File: rtl/seg_charge_bar_display.sv
// Jump-charge bar graph on the 8-digit 7-segment display: digit scan with
// anti-ghost blanking, once-per-frame level latch and full-charge blink.
module seg_charge_bar_display
  import seg_pkg::*;
#(
  parameter int PHY_WIDTH    = 16,
  parameter int SCAN_DIV     = 12500,
  parameter int BLANK_CYCLES = 500,
  parameter int CHARGE_SHIFT = 2,
  parameter int BLINK_FRAMES = 250
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic [PHY_WIDTH-1:0] charge_bar,
  output logic                 CA,
  output logic                 CB,
  output logic                 CC,
  output logic                 CD,
  output logic                 CE,
  output logic                 CF,
  output logic                 CG,
  output logic                 DP,
  output logic [7:0]           AN
);

  localparam int TIMER_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [TIMER_W-1:0]   TIMER_LAST = TIMER_W'(SCAN_DIV - 1);
  localparam logic [TIMER_W-1:0]   BLANK_LAST = TIMER_W'(BLANK_CYCLES - 1);
  localparam logic [BLINK_W-1:0]   BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);
  localparam logic [PHY_WIDTH-1:0] FULL_STEPS = PHY_WIDTH'(BAR_STEPS);

  logic [TIMER_W-1:0]   timer;
  digit_t               k;
  scan_state_t          state;
  scan_state_t          state_nx;
  level_t               level;
  level_t               level_in;
  logic [PHY_WIDTH-1:0] charge_steps;
  logic [BLINK_W-1:0]   blink_cnt;
  logic                 blink_on;
  logic                 level_full;
  logic                 blink_off;
  logic                 slot_end;
  logic                 frame_end;
  logic                 frame_start;
  logic [6:0]           dec_segs;
  logic [6:0]           seg_q;
  logic [7:0]           an_q;

  always_comb begin
    slot_end     = (timer == TIMER_LAST);
    frame_end    = slot_end && (k == digit_t'(DIGITS - 1));
    frame_start  = (timer == '0) && (k == '0);
    charge_steps = charge_bar >> CHARGE_SHIFT;
    level_in     = (charge_steps >= FULL_STEPS) ? level_t'(BAR_STEPS) : charge_steps[4:0];
    level_full   = (level == level_t'(BAR_STEPS));
    blink_off    = level_full && !blink_on;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_BLANK: if (timer == BLANK_LAST) state_nx = ST_DRIVE;
      ST_DRIVE: if (slot_end) state_nx = ST_BLANK;
      default:  state_nx = ST_BLANK;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      timer <= '0;
      k     <= '0;
      state <= ST_BLANK;
    end else begin
      state <= state_nx;
      if (slot_end) begin
        timer <= '0;
        k     <= k + 3'd1;
      end else begin
        timer <= timer + 1'b1;
      end
    end
  end

  // Level is sampled only at the top of a frame so a frame never tears.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) level <= '0;
    else if (frame_start) level <= level_in;
  end

  // Any non-full frame re-arms the blink so the first full frame shows lit.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (!level_full) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (frame_end) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  seg_bar_decode u_decode (
    .level     (level),
    .k         (k),
    .blink_off (blink_off),
    .segs      (dec_segs)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      an_q  <= 8'hFF;
      seg_q <= SEG_OFF;
    end else if (state == ST_DRIVE) begin
      an_q  <= ~(8'd1 << k);
      seg_q <= dec_segs;
    end else begin
      an_q  <= 8'hFF;
      seg_q <= SEG_OFF;
    end
  end

  assign AN = an_q;
  assign {CG, CF, CE, CD, CC, CB, CA} = seg_q;
  assign DP = 1'b1;

endmodule

// File: tb/tb_seg_charge_bar_display.sv
// Self-checking bench for seg_charge_bar_display against a cycle-indexed
// reference model of the scan, the per-frame bar level and the blink rule.
module tb_seg_charge_bar_display;

  localparam int SD    = 16;
  localparam int BC    = 4;
  localparam int CS    = 2;
  localparam int BF    = 2;
  localparam int FRAME = SD * 8;
  localparam int MAXF  = 64;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [15:0] charge_bar = 16'd0;
  logic        CA, CB, CC, CD, CE, CF, CG, DP;
  logic [7:0]  AN;
  logic [6:0]  segs;

  int total = 0;
  int bad = 0;
  int m = 0;
  int lvl_hist[MAXF];
  int run_hist[MAXF];
  logic [6:0] exp_q[$];

  assign segs = {CG, CF, CE, CD, CC, CB, CA};

  seg_charge_bar_display #(
    .PHY_WIDTH    (16),
    .SCAN_DIV     (SD),
    .BLANK_CYCLES (BC),
    .CHARGE_SHIFT (CS),
    .BLINK_FRAMES (BF)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .charge_bar (charge_bar),
    .CA (CA), .CB (CB), .CC (CC), .CD (CD), .CE (CE), .CF (CF), .CG (CG),
    .DP (DP),
    .AN (AN)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic int bar_level(input logic [15:0] c);
    int s = int'(c) >> CS;
    return (s > 16) ? 16 : s;
  endfunction

  function automatic logic [6:0] digit_pattern(input int lvl, input int k);
    int i = 7 - k;
    if (lvl >= 2 * i + 2) return 7'b1001001;
    if (lvl >= 2 * i + 1) return 7'b1001111;
    return 7'h7F;
  endfunction

  // Expected pins while the design is in state cycle c (pins lag by one cycle).
  function automatic void model(input int c, output logic [7:0] an, output logic [6:0] sg);
    int tmr = c % SD;
    int k = (c / SD) % 8;
    int f = c / FRAME;
    an = 8'hFF;
    sg = 7'h7F;
    if (c < 0 || tmr < BC) return;
    an = ~(8'd1 << k);
    if (((run_hist[f] / BF) % 2) == 0) sg = digit_pattern(lvl_hist[f], k);
  endfunction

  task automatic clear_model();
    m = 0;
    for (int i = 0; i < MAXF; i++) begin
      lvl_hist[i] = 0;
      run_hist[i] = 0;
    end
  endtask

  task automatic do_reset(input logic [15:0] chg);
    sys_rst_n = 1'b0;
    charge_bar = chg;
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    clear_model();
  endtask

  // Advance one clock; record the frame's level at the frame's first cycle.
  task automatic tick(output logic [7:0] ea, output logic [6:0] es);
    int f;
    if (m % FRAME == 0) begin
      f = m / FRAME;
      lvl_hist[f] = bar_level(charge_bar);
      run_hist[f] = (lvl_hist[f] == 16 && f > 0 && lvl_hist[f-1] == 16) ? run_hist[f-1] + 1 : 0;
    end
    @(posedge sys_clk);
    #1;
    m++;
    model(m - 1, ea, es);
  endtask

  task automatic test_reset();
    logic [7:0] ea;
    logic [6:0] es;
    sys_rst_n = 1'b0;
    charge_bar = 16'd0;
    repeat (3) @(posedge sys_clk);
    #1;
    total++; if (AN !== 8'hFF) begin bad++; $display("FAIL rst_an got=%h exp=ff", AN); end
    total++; if (segs !== 7'h7F) begin bad++; $display("FAIL rst_seg got=%h exp=7f", segs); end
    total++; if (DP !== 1'b1) begin bad++; $display("FAIL rst_dp got=%b exp=1", DP); end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    clear_model();
    for (int n = 0; n < 24; n++) begin
      tick(ea, es);
      total++; if (AN !== ea) begin bad++; $display("FAIL rst_scan_an m=%0d got=%h exp=%h", m, AN, ea); end
      total++; if (segs !== 7'h7F) begin bad++; $display("FAIL rst_scan_seg m=%0d got=%h exp=7f", m, segs); end
      if (m <= 4) begin
        total++; if (AN !== 8'hFF) begin bad++; $display("FAIL rst_blank m=%0d got=%h exp=ff", m, AN); end
      end
      if (m == 5) begin
        total++; if (AN !== 8'hFE) begin bad++; $display("FAIL rst_first_an got=%h exp=fe", AN); end
      end
      if (m == 21) begin
        total++; if (AN !== 8'hFD) begin bad++; $display("FAIL rst_slot1_an got=%h exp=fd", AN); end
      end
    end
  endtask

  task automatic test_level5();
    logic [7:0] ea;
    logic [6:0] es;
    logic [6:0] want;
    do_reset(16'd20);
    exp_q.delete();
    for (int k = 0; k < 5; k++) exp_q.push_back(7'h7F);
    exp_q.push_back(7'b1001111);
    exp_q.push_back(7'b1001001);
    exp_q.push_back(7'b1001001);
    for (int n = 0; n < 2 * FRAME; n++) begin
      tick(ea, es);
      total++; if (AN !== ea) begin bad++; $display("FAIL l5_an m=%0d got=%h exp=%h", m, AN, ea); end
      total++; if (segs !== es) begin bad++; $display("FAIL l5_seg m=%0d got=%h exp=%h", m, segs, es); end
      if ((m - 1) / FRAME == 1 && (m - 1) % SD == 8) begin
        want = exp_q.pop_front();
        total++; if (segs !== want) begin bad++; $display("FAIL l5_digit m=%0d got=%b exp=%b", m, segs, want); end
      end
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL l5_drain got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_midframe();
    logic [7:0] ea;
    logic [6:0] es;
    logic [6:0] want;
    do_reset(16'd0);
    for (int n = 0; n < 2 * FRAME; n++) begin
      if (m == 3 * SD) charge_bar = 16'd63;
      tick(ea, es);
      total++; if (segs !== es) begin bad++; $display("FAIL mid_seg m=%0d got=%h exp=%h", m, segs, es); end
      if ((m - 1) / FRAME == 0) begin
        total++; if (segs !== 7'h7F) begin bad++; $display("FAIL mid_hold m=%0d got=%h exp=7f", m, segs); end
      end
      if ((m - 1) / FRAME == 1 && (m - 1) % SD == 8) begin
        want = ((m - 1) % FRAME < SD) ? 7'b1001111 : 7'b1001001;
        total++; if (segs !== want) begin bad++; $display("FAIL mid_l15 m=%0d got=%b exp=%b", m, segs, want); end
      end
    end
  endtask

  task automatic test_full_blink();
    logic [7:0] ea;
    logic [6:0] es;
    int f;
    do_reset(16'hFFFF);
    for (int n = 0; n < 8 * FRAME; n++) begin
      if (m == 6 * FRAME) charge_bar = 16'd0;
      if (m == 7 * FRAME) charge_bar = 16'hFFFF;
      tick(ea, es);
      f = (m - 1) / FRAME;
      total++; if (AN !== ea) begin bad++; $display("FAIL blk_an m=%0d got=%h exp=%h", m, AN, ea); end
      total++; if (segs !== es) begin bad++; $display("FAIL blk_seg m=%0d got=%h exp=%h", m, segs, es); end
      if (f == 2 || f == 3) begin
        total++; if (segs !== 7'h7F) begin bad++; $display("FAIL blk_off m=%0d got=%h exp=7f", m, segs); end
      end
      if ((f <= 1 || f == 4 || f == 5 || f == 7) && (m - 1) % SD == 8) begin
        total++; if (segs !== 7'b1001001) begin bad++; $display("FAIL blk_lit m=%0d got=%b exp=1001001", m, segs); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] ea;
    logic [6:0] es;
    do_reset(16'd20);
    while (m < 5 * SD + 9) tick(ea, es);
    total++; if (AN !== 8'hDF) begin bad++; $display("FAIL rmid_pre got=%h exp=df", AN); end
    sys_rst_n = 1'b0;
    charge_bar = 16'hFFFF;
    #1;
    total++; if (AN !== 8'hFF) begin bad++; $display("FAIL rmid_an got=%h exp=ff", AN); end
    total++; if (segs !== 7'h7F) begin bad++; $display("FAIL rmid_seg got=%h exp=7f", segs); end
    @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    clear_model();
    for (int n = 0; n < 8; n++) begin
      tick(ea, es);
      total++; if (AN !== ea) begin bad++; $display("FAIL rmid_scan m=%0d got=%h exp=%h", m, AN, ea); end
      if (m <= 4) begin
        total++; if (AN !== 8'hFF) begin bad++; $display("FAIL rmid_blank m=%0d got=%h exp=ff", m, AN); end
      end
      if (m == 5) begin
        total++; if (AN !== 8'hFE) begin bad++; $display("FAIL rmid_first got=%h exp=fe", AN); end
        total++; if (segs !== 7'b1001001) begin bad++; $display("FAIL rmid_relatch got=%b exp=1001001", segs); end
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] ea;
    logic [6:0] es;
    do_reset(16'($urandom_range(0, 70)));
    for (int n = 0; n < 10 * FRAME; n++) begin
      if ($urandom_range(0, 99) < 3) begin
        case ($urandom_range(0, 3))
          0: charge_bar = 16'($urandom_range(0, 70));
          1: charge_bar = 16'hFFFF;
          2: charge_bar = 16'($urandom_range(60, 68));
          default: charge_bar = 16'($urandom);
        endcase
      end
      tick(ea, es);
      total++; if (AN !== ea) begin bad++; $display("FAIL rnd_an m=%0d got=%h exp=%h", m, AN, ea); end
      total++; if (segs !== es) begin bad++; $display("FAIL rnd_seg m=%0d got=%h exp=%h", m, segs, es); end
      total++; if ($countones(~AN) > 1) begin bad++; $display("FAIL rnd_onehot m=%0d got=%h exp=<=1 low", m, AN); end
      total++; if (DP !== 1'b1) begin bad++; $display("FAIL rnd_dp m=%0d got=%b exp=1", m, DP); end
      if ((m - 1) % SD < BC) begin
        total++; if (AN !== 8'hFF) begin bad++; $display("FAIL rnd_blank m=%0d got=%h exp=ff", m, AN); end
      end
    end
  endtask

  initial begin
    clear_model();
    test_reset();
    test_level5();
    test_midframe();
    test_full_blink();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
